// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: chooses the next PC, drives the PC register load
// controls and runs the imem req/ack handshake. Option macro: FETCH_ALIGN_CHECK_EN.
module fetch_seq #(
   parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC    = 32'h0000_0180,
   parameter logic [31:0] INSN_BYTES = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cur_pc,
   input  logic        stall,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc_in,
   input  logic        jmp_take,
   input  logic [31:0] jmp_target,
   input  logic        br_take,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] insn,
   output logic        insn_valid,
   output logic [31:0] npc,
   output logic        pc_change,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        misalign_exc,
`endif
   output logic        pause
);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [1:0] PRIO_EXC  = 2'd3;
   localparam logic [1:0] PRIO_ERET = 2'd2;
   localparam logic [1:0] PRIO_JMP  = 2'd1;
   localparam logic [1:0] PRIO_BR   = 2'd0;

   logic [1:0]  r_state;
   logic [31:0] r_insn;
   logic        r_insn_valid;
   logic        r_pend_valid;
   logic [31:0] r_pend_tgt;
   logic [1:0]  r_pend_prio;

   logic        w_redir;
   logic [31:0] w_redir_tgt;
   logic [1:0]  w_redir_prio;
   logic        w_new_wins;
   logic [31:0] w_seq_pc;
   logic [1:0]  w_next_state;
   logic        w_pc_change;
   logic        w_is_redir;
   logic [31:0] w_sel_tgt;
   logic [31:0] w_npc_base;
   logic [31:0] w_fixed_tgt;
   logic        w_pend_load;
   logic        w_pend_clr;
   logic        w_capture;
   logic        w_valid_set;

   assign w_redir  = exc_req | eret | jmp_take | br_take;
   assign w_seq_pc = cur_pc + INSN_BYTES;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_redir_tgt  = br_target;
      w_redir_prio = PRIO_BR;
      if (exc_req) begin
         w_redir_tgt  = EXC_VEC;
         w_redir_prio = PRIO_EXC;
      end else if (eret) begin
         w_redir_tgt  = epc_in;
         w_redir_prio = PRIO_ERET;
      end else if (jmp_take) begin
         w_redir_tgt  = jmp_target;
         w_redir_prio = PRIO_JMP;
      end
   end

   // Equal priority lets the newer redirect replace the held one.
   assign w_new_wins = ~r_pend_valid | (w_redir_prio >= r_pend_prio);

   always_comb begin
      w_next_state = r_state;
      w_pc_change  = 1'b0;
      w_is_redir   = 1'b0;
      w_sel_tgt    = w_redir_tgt;
      w_npc_base   = w_seq_pc;
      w_pend_load  = 1'b0;
      w_pend_clr   = 1'b0;
      w_capture    = 1'b0;
      w_valid_set  = 1'b0;
      case (r_state)
         S_BOOT: begin
            w_pc_change  = 1'b1;
            w_npc_base   = RESET_VEC;
            w_next_state = S_IDLE;
         end
         S_IDLE: begin
            if (w_redir) begin
               w_pc_change = 1'b1;
               w_is_redir  = 1'b1;
            end else if (!stall) begin
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!imem_ack) begin
               w_pend_load = w_redir & w_new_wins;
            end else if (w_redir || r_pend_valid) begin
               w_pc_change  = 1'b1;
               w_is_redir   = 1'b1;
               w_sel_tgt    = (w_redir && w_new_wins) ? w_redir_tgt : r_pend_tgt;
               w_pend_clr   = 1'b1;
               w_next_state = S_IDLE;
            end else if (stall) begin
               w_capture    = 1'b1;
               w_next_state = S_HOLD;
            end else begin
               w_capture   = 1'b1;
               w_valid_set = 1'b1;
               w_pc_change = 1'b1;
            end
         end
         S_HOLD: begin
            if (w_redir) begin
               w_pc_change  = 1'b1;
               w_is_redir   = 1'b1;
               w_next_state = S_IDLE;
            end else if (!stall) begin
               w_valid_set  = 1'b1;
               w_pc_change  = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_BOOT;
      endcase
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic w_misalign;
   assign w_misalign   = w_is_redir & (w_sel_tgt[1:0] != 2'b00);
   assign w_fixed_tgt  = w_misalign ? EXC_VEC : w_sel_tgt;
   assign misalign_exc = w_misalign & ~rst;
`else
   assign w_fixed_tgt  = w_sel_tgt;
`endif

   // Reset forces the PC controls quiet even though S_BOOT would request a load.
   assign pc_change  = w_pc_change & ~rst;
   assign pause      = ~pc_change;
   assign npc        = rst ? 32'h0 : (w_is_redir ? w_fixed_tgt : w_npc_base);
   assign imem_req   = (r_state == S_WAIT);
   assign imem_addr  = cur_pc;
   assign insn       = r_insn;
   assign insn_valid = r_insn_valid;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_BOOT;
         r_insn       <= 32'h0;
         r_insn_valid <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_tgt   <= 32'h0;
         r_pend_prio  <= 2'd0;
      end else begin
         r_state      <= w_next_state;
         r_insn_valid <= w_valid_set;
         if (w_capture) r_insn <= imem_rdata;
         if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
         end else if (w_pend_load) begin
            r_pend_valid <= 1'b1;
            r_pend_tgt   <= w_redir_tgt;
            r_pend_prio  <= w_redir_prio;
         end
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: PC register model, insn scoreboard queue, and
// immediate-assertion checks at each step.
module tb_fetch_seq;

   logic        clk;
   logic        rst;
   logic [31:0] cur_pc;
   logic        stall;
   logic        exc_req;
   logic        eret;
   logic [31:0] epc_in;
   logic        jmp_take;
   logic [31:0] jmp_target;
   logic        br_take;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] insn;
   logic        insn_valid;
   logic [31:0] npc;
   logic        pc_change;
   logic        pause;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_exc;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   fetch_seq dut (
      .clk        (clk),
      .rst        (rst),
      .cur_pc     (cur_pc),
      .stall      (stall),
      .exc_req    (exc_req),
      .eret       (eret),
      .epc_in     (epc_in),
      .jmp_take   (jmp_take),
      .jmp_target (jmp_target),
      .br_take    (br_take),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .insn       (insn),
      .insn_valid (insn_valid),
      .npc        (npc),
      .pc_change  (pc_change),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalign_exc (misalign_exc),
`endif
      .pause      (pause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment model of the PC register loaded by npc/pc_change.
   always @(posedge clk or posedge rst) begin
      if (rst) cur_pc <= 32'h0;
      else if (pc_change) cur_pc <= npc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   // Scoreboard: every delivered instruction must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && insn_valid === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_insn_valid", 32'(insn_valid), 32'h0);
         else check("insn", insn, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; exc_req = 1'b0; eret = 1'b0; epc_in = 32'h0;
      jmp_take = 1'b0; jmp_target = 32'h0; br_take = 1'b0; br_target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;

      // Reset state
      step(); settle();
      check("rst_imem_req", 32'(imem_req), 32'h0);
      check("rst_insn_valid", 32'(insn_valid), 32'h0);
      check("rst_pc_change", 32'(pc_change), 32'h0);
      check("rst_pause", 32'(pause), 32'h1);
      check("rst_insn", insn, 32'h0);
      check("rst_npc", npc, 32'h0);

      // Boot then back-to-back fetches with ack tied high
      step(); rst = 1'b0; imem_ack = 1'b1; settle();
      check("boot_pc_change", 32'(pc_change), 32'h1);
      check("boot_npc", npc, 32'h0);
      step(); settle();
      check("idle_imem_req", 32'(imem_req), 32'h0);
      check("idle_pc_change", 32'(pc_change), 32'h0);
      step(); imem_rdata = 32'h1000_0000; exp_q.push_back(32'h1000_0000); settle();
      check("f0_req", 32'(imem_req), 32'h1);
      check("f0_addr", imem_addr, 32'h0);
      check("f0_npc", npc, 32'h4);
      check("f0_pc_change", 32'(pc_change), 32'h1);
      step(); imem_rdata = 32'h1000_0004; exp_q.push_back(32'h1000_0004); settle();
      check("f1_addr", imem_addr, 32'h4);
      check("f1_npc", npc, 32'h8);
      step(); imem_rdata = 32'h1000_0008; exp_q.push_back(32'h1000_0008); settle();
      check("f2_addr", imem_addr, 32'h8);
      check("f2_npc", npc, 32'hC);

      // Delayed ack with a branch arriving mid-wait
      step(); imem_ack = 1'b0; settle();
      check("dly_w1_addr", imem_addr, 32'hC);
      check("dly_w1_pc_change", 32'(pc_change), 32'h0);
      step(); br_take = 1'b1; br_target = 32'h40; settle();
      check("dly_w2_pc_change", 32'(pc_change), 32'h0);
      check("dly_w2_addr", imem_addr, 32'hC);
      step(); br_take = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001; settle();
      check("dly_ack_pc_change", 32'(pc_change), 32'h1);
      check("dly_ack_npc", npc, 32'h40);
      step(); imem_ack = 1'b0; settle();
      check("dly_idle_req", 32'(imem_req), 32'h0);
      check("dly_discard_valid", 32'(insn_valid), 32'h0);
      step(); settle();
      check("dly_refetch_req", 32'(imem_req), 32'h1);
      check("dly_refetch_addr", imem_addr, 32'h40);

      // Branch then exception while waiting: exception wins
      br_take = 1'b1; br_target = 32'h40;
      step(); br_take = 1'b0; exc_req = 1'b1; settle();
      check("be_pend_pc_change", 32'(pc_change), 32'h0);
      step(); exc_req = 1'b0; imem_ack = 1'b1; settle();
      check("be_npc", npc, 32'h180);
      step(); imem_ack = 1'b0;
      step(); exc_req = 1'b1; settle();
      check("eb_addr", imem_addr, 32'h180);
      step(); exc_req = 1'b0; br_take = 1'b1; br_target = 32'h40; settle();
      check("eb_pend_pc_change", 32'(pc_change), 32'h0);
      step(); br_take = 1'b0; imem_ack = 1'b1; settle();
      check("eb_npc", npc, 32'h180);
      step(); imem_ack = 1'b0;

      // Stall at ack time holds the word
      step(); stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      exp_q.push_back(32'hDEAD_BEEF); settle();
      check("stall_ack_addr", imem_addr, 32'h180);
      check("stall_ack_pc_change", 32'(pc_change), 32'h0);
      check("stall_ack_pause", 32'(pause), 32'h1);
      step(); imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("hold_insn_valid", 32'(insn_valid), 32'h0);
         check("hold_pause", 32'(pause), 32'h1);
         check("hold_req", 32'(imem_req), 32'h0);
         step();
      end
      stall = 1'b0; settle();
      check("unstall_pc_change", 32'(pc_change), 32'h1);
      check("unstall_npc", npc, 32'h184);
      step(); settle();
      check("unstall_insn", insn, 32'hDEAD_BEEF);
      check("unstall_insn_valid", 32'(insn_valid), 32'h1);

      // Jump to the top of memory, then wrap the sequential PC
      step(); jmp_take = 1'b1; jmp_target = 32'hFFFF_FFFC; imem_ack = 1'b1; settle();
      check("jmp_addr", imem_addr, 32'h184);
      check("jmp_npc", npc, 32'hFFFF_FFFC);
      step(); jmp_take = 1'b0; imem_ack = 1'b0;
      step(); imem_ack = 1'b1; imem_rdata = 32'h1234_5678; exp_q.push_back(32'h1234_5678); settle();
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      check("wrap_npc", npc, 32'h0);

      // Mid-fetch reset drops req at once; ack during and after reset ignored
      step(); imem_ack = 1'b0; settle();
      check("pre_rst_req", 32'(imem_req), 32'h1);
      #1 rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0002; settle();
      check("midrst_req", 32'(imem_req), 32'h0);
      check("midrst_pc_change", 32'(pc_change), 32'h0);
      step(); settle();
      check("midrst_insn", insn, 32'h0);
      step(); rst = 1'b0; settle();
      check("reboot_pc_change", 32'(pc_change), 32'h1);
      check("reboot_npc", npc, 32'h0);

      // Idle redirect priority (eret over jump/branch) overrides stall
      step(); imem_ack = 1'b0; stall = 1'b1;
      eret = 1'b1; epc_in = 32'h200; jmp_take = 1'b1; jmp_target = 32'h300;
      br_take = 1'b1; br_target = 32'h40; settle();
      check("reboot_ack_ignored", 32'(insn_valid), 32'h0);
      check("idle_redir_pc_change", 32'(pc_change), 32'h1);
      check("idle_redir_npc", npc, 32'h200);
      step(); eret = 1'b0; jmp_take = 1'b0; br_take = 1'b0; settle();
      check("idle_stall_pc_change", 32'(pc_change), 32'h0);
      check("idle_stall_req", 32'(imem_req), 32'h0);
      step(); stall = 1'b0; settle();
      check("idle_unstall_req", 32'(imem_req), 32'h0);
      step(); settle();
      check("fetch_200_req", 32'(imem_req), 32'h1);
      check("fetch_200_addr", imem_addr, 32'h200);

      // Misaligned jump target
      jmp_take = 1'b1; jmp_target = 32'h102; imem_ack = 1'b1; settle();
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign_npc", npc, 32'h180);
      check("misalign_pulse", 32'(misalign_exc), 32'h1);
`else
      check("unaligned_npc", npc, 32'h102);
`endif
      step(); jmp_take = 1'b0; imem_ack = 1'b0; settle();
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign_drop", 32'(misalign_exc), 32'h0);
`endif
      check("final_pc_change", 32'(pc_change), 32'h0);

      step(); step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Sequences instruction fetch by driving the program-counter register's load inputs (next-PC, pc_change, pause) and the instruction-memory req/ack handshake.
- Selects the next PC by priority: exception, exception return, jump, branch, sequential.
- Holds redirects that arrive while a fetch is outstanding, and buffers one fetched word while the pipeline is stalled.
- Sits between the hazard/branch/exception logic and the PC register at the front of the CPU pipeline.

Parameters:
- RESET_VEC, 32'h0000_0000, address loaded into the PC one cycle after reset.
- EXC_VEC, 32'h0000_0180, exception handler entry address.
- INSN_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cur_pc  in  32  current PC from the PC register
- stall  in  1  hazard stall request from the pipeline
- exc_req  in  1  exception redirect
- eret  in  1  exception return
- epc_in  in  32  exception return target
- jmp_take  in  1  jump redirect
- jmp_target  in  32  jump target
- br_take  in  1  taken-branch redirect
- br_target  in  32  branch target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  32  fetched word
- insn  out  32  instruction to decode
- insn_valid  out  1  insn is valid this cycle
- npc  out  32  next PC to the PC register
- pc_change  out  1  PC load enable
- pause  out  1  PC hold

Behaviour:
- Reset and clock: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - State is S_BOOT.
  - imem_req=0, insn_valid=0, pc_change=0, pause=1.
  - insn=0, npc=0, pending redirect cleared.
- Mid-operation reset: asserting reset drops imem_req immediately. An ack arriving during reset is ignored.
- Fetch address: imem_addr=cur_pc combinationally. It must stay stable while imem_req=1.
- Redirect now (redir) = exc_req|eret|jmp_take|br_take.
  - Target priority: EXC_VEC > epc_in > jmp_target > br_target.
  - A redirect overrides stall.
- Sequential next PC = cur_pc+INSN_BYTES, computed modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Pending register (valid bit + 32-bit target + 2-bit priority):
  - A redirect arriving in S_WAIT without ack is latched.
  - A later redirect replaces the pending one only if its priority is greater than or equal to the pending priority.
- PC control rule:
  - pause = ~pc_change, always.
  - pc_change is a single-cycle pulse.
- State S_BOOT:
  - pc_change=1, npc=RESET_VEC.
  - Go to S_IDLE.
- State S_IDLE:
  - imem_req=0.
  - If redir: pc_change=1, npc=target; stay in S_IDLE.
  - Else if stall: stay in S_IDLE.
  - Else: go to S_WAIT.
- State S_WAIT (imem_req=1):
  - No ack: latch any redir into pending; stay in S_WAIT.
  - Ack with redir or pending valid: discard the fetched word (insn_valid=0). pc_change=1, npc = the higher-priority target of redir and pending. Clear pending. Go to S_IDLE.
  - Ack with stall: insn<=imem_rdata. Go to S_HOLD. PC is not changed.
  - Ack, otherwise: insn<=imem_rdata, insn_valid=1, pc_change=1, npc=sequential. Stay in S_WAIT; the next request issues back-to-back.
- State S_HOLD (imem_req=0, insn held):
  - redir: discard the held word, pc_change=1, npc=target. Go to S_IDLE.
  - Else if stall: insn_valid=0; stay in S_HOLD.
  - Else: insn_valid=1, pc_change=1, npc=sequential. Go to S_IDLE.
- Output timing: insn_valid and insn are registered (1-cycle latency from ack). npc and pc_change are combinational from state and inputs.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_exc (1 bit).
  - Any selected redirect target with bits [1:0] != 0 is replaced by EXC_VEC.
  - misalign_exc pulses for one cycle coincident with that pc_change.
- Undefined:
  - There is no port.
  - Targets are used unmodified.

Test Plan:
- Reset release, imem_ack tied to 1 each cycle, no stall:
  - cycle 1: pc_change=1, npc=RESET_VEC.
  - Then fetches at 0, 4, 8 back-to-back, with insn_valid one cycle after each ack.
- Ack delayed 3 cycles, br_take=1 (br_target=32'h40) in the 2nd wait cycle:
  - On ack: word discarded, npc=32'h40.
  - Next fetch address is 32'h40.
- In S_WAIT, br_take (32'h40) then exc_req one cycle later, both before ack:
  - On ack: npc=EXC_VEC.
  - Reverse order (exc first, then branch) also gives EXC_VEC.
- stall=1 when ack arrives with rdata=32'hDEAD_BEEF, stall held 4 cycles:
  - insn_valid=0 and pause=1 during the stall.
  - After stall drops: insn=32'hDEAD_BEEF, insn_valid=1, npc=cur_pc+4.
- cur_pc=32'hFFFF_FFFC, ack, no stall: npc=32'h0000_0000.
- Reset asserted while imem_req=1: imem_req=0 the same cycle, and the next ack is ignored. With FETCH_ALIGN_CHECK_EN, jmp_target=32'h102 gives npc=EXC_VEC and a misalign_exc pulse.
